// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU control sequencer:
// opcodes, control-word bit positions and the microcode ROM output bundle.
package cpu_pkg;

    localparam int NUM_T = 6;
    localparam int CW_W  = 15;
    localparam int TW    = $clog2(NUM_T);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_CP   = 14;
    localparam int CW_EP   = 13;
    localparam int CW_LP   = 12;
    localparam int CW_NLMA = 11;
    localparam int CW_NLMD = 10;
    localparam int CW_NCE  = 9;
    localparam int CW_NLR  = 8;
    localparam int CW_NLI  = 7;
    localparam int CW_NEI  = 6;
    localparam int CW_NLA  = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SUB  = 3;
    localparam int CW_EU   = 2;
    localparam int CW_NLB  = 1;
    localparam int CW_NLO  = 0;

    localparam logic [CW_W-1:0] CW_IDLE = 15'h0FE3;

    typedef struct packed {
        logic [CW_W-1:0] cw;
        logic            last_step;
        logic            do_halt;
    } ucode_t;

endpackage

// File: rtl/cpu_microcode_rom.sv
// Combinational microcode: {t_state, opcode, flags} -> control word,
// end-of-instruction marker and halt request.
module cpu_microcode_rom
    import cpu_pkg::*;
(
    input  logic [TW-1:0] t_state,
    input  logic [3:0]    opcode,
    input  logic          cf,
    input  logic          zf,
    output ucode_t        ucode
);

    logic take;

    always_comb begin
        ucode           = '0;
        ucode.cw        = CW_IDLE;
        ucode.last_step = 1'b0;
        ucode.do_halt   = 1'b0;
        take            = 1'b0;
        case (t_state)
            3'd0: begin
                ucode.cw[CW_EP]   = 1'b1;
                ucode.cw[CW_NLMA] = 1'b0;
            end
            3'd1: begin
                ucode.cw[CW_CP]  = 1'b1;
                ucode.cw[CW_NCE] = 1'b0;
                ucode.cw[CW_NLI] = 1'b0;
            end
            default: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        if (t_state == 3'd2) begin
                            ucode.cw[CW_NEI]  = 1'b0;
                            ucode.cw[CW_NLMA] = 1'b0;
                        end else if (t_state == 3'd3) begin
                            if (opcode == OP_STA) begin
                                ucode.cw[CW_EA]   = 1'b1;
                                ucode.cw[CW_NLMD] = 1'b0;
                            end else begin
                                ucode.cw[CW_NCE] = 1'b0;
                                if (opcode == OP_LDA) begin
                                    ucode.cw[CW_NLA] = 1'b0;
                                    ucode.last_step  = 1'b1;
                                end else begin
                                    ucode.cw[CW_NLB] = 1'b0;
                                end
                            end
                        end else if (t_state == 3'd4) begin
                            ucode.last_step = 1'b1;
                            if (opcode == OP_STA) begin
                                ucode.cw[CW_NLR] = 1'b0;
                            end else begin
                                ucode.cw[CW_EU]  = 1'b1;
                                ucode.cw[CW_NLA] = 1'b0;
                                ucode.cw[CW_SUB] = (opcode == OP_SUB);
                            end
                        end else begin
                            ucode.last_step = 1'b1;
                        end
                    end
                    OP_LDI: begin
                        ucode.cw[CW_NEI] = 1'b0;
                        ucode.cw[CW_NLA] = 1'b0;
                        ucode.last_step  = 1'b1;
                    end
                    OP_JMP, OP_JC, OP_JZ: begin
                        // Flags only matter here in T2; jumps finish in T2
                        take = (opcode == OP_JMP)
                            || (opcode == OP_JC && cf)
                            || (opcode == OP_JZ && zf);
                        if (take) begin
                            ucode.cw[CW_NEI] = 1'b0;
                            ucode.cw[CW_LP]  = 1'b1;
                        end
                        ucode.last_step = 1'b1;
                    end
                    OP_OUT: begin
                        ucode.cw[CW_EA]  = 1'b1;
                        ucode.cw[CW_NLO] = 1'b0;
                        ucode.last_step  = 1'b1;
                    end
                    OP_HLT: begin
                        ucode.do_halt   = 1'b1;
                        ucode.last_step = 1'b1;
                    end
                    default: begin
                        ucode.last_step = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// T-state counter, halt flag, run gating and reset override around
// the microcode ROM of the SAP-style CPU.
module cpu_control_sequencer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [3:0]      opcode,
    input  logic            cf,
    input  logic            zf,
    output logic [CW_W-1:0] control_signals,
    output logic [2:0]      t_state,
    output logic            halted
);

    ucode_t ucode;
    logic   active;

    cpu_microcode_rom u_rom (
        .t_state (t_state),
        .opcode  (opcode),
        .cf      (cf),
        .zf      (zf),
        .ucode   (ucode)
    );

    assign active = run && !halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state <= '0;
            halted  <= 1'b0;
        end else if (active) begin
            if (ucode.last_step || t_state == 3'(NUM_T - 1))
                t_state <= '0;
            else
                t_state <= t_state + 3'd1;
            if (ucode.do_halt)
                halted <= 1'b1;
        end
    end

    assign control_signals = (rst || !active) ? CW_IDLE : ucode.cw;

endmodule
